mem_access_stage: RTL and testbench

Memory stage of the five-stage pipeline: sits between the EXE/MEM pipeline register and writeback. Drives loads and stores onto a variable-latency data-memory port with a req/ack handshake. Stalls upstream stages until each access completes, with a timeout on every access. Registers the result into the MEM/WB pipeline register consumed by the writeback stage.

---
 rtl/mem_access_stage_if.sv | 28 ++
 rtl/mem_access_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory port of the memory stage: req/ack handshake with a variable-latency memory.
// The stage is the master; the data memory (or its model) is the slave.
interface mem_access_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ack
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_rdata,
        output dm_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: issues loads/stores on a req/ack data port, stalls upstream until
// each access completes or times out, and registers the result into the MEM/WB register.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mwreg,
    input  logic                mm2reg,
    input  logic                mwmem,
    input  logic [31:0]         maluout,
    input  logic [31:0]         mdata_b,
    input  logic [4:0]          mrdrt,
    input  logic [3:0]          MEM_ins_type,
    input  logic [3:0]          MEM_ins_number,
    mem_access_stage_if.master  dm,
    output logic                mem_stall,
    output logic                mem_err,
    output logic                wwreg,
    output logic                wm2reg,
    output logic [31:0]         wmo,
    output logic [31:0]         walu,
    output logic [4:0]          wrn,
    output logic [3:0]          WB_ins_type,
    output logic [3:0]          WB_ins_number
);

    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            gap_q, gap_d;

    logic            access;
    logic            is_store;
    logic            is_load;
    logic            misaligned;
    logic            timeout_hit;

    logic            req;
    logic            load_instr;

    logic            wwreg_q, wwreg_d;
    logic            wm2reg_q, wm2reg_d;
    logic [31:0]     wmo_q, wmo_d;
    logic [31:0]     walu_q, walu_d;
    logic [4:0]      wrn_q, wrn_d;
    logic [3:0]      wb_type_q, wb_type_d;
    logic [3:0]      wb_num_q, wb_num_d;

    assign access      = mm2reg | mwmem;
    assign is_store    = mwmem;
    assign is_load     = mm2reg & ~mwmem;
    assign misaligned  = access & (maluout[1:0] != 2'b00);
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

    // FSM and handshake control. load_instr selects the real instruction into MEM/WB;
    // otherwise MEM/WB takes a bubble.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = 1'b0;
        req        = 1'b0;
        mem_stall  = 1'b0;
        mem_err    = 1'b0;
        load_instr = 1'b0;

        case (state_q)
            StIdle: begin
                if (!access) begin
                    load_instr = 1'b1;
                end else if (misaligned) begin
                    mem_err = 1'b1;
                end else if (gap_q) begin
                    // Hold off one cycle after an acked access so dm_req always drops between
                    // two accesses.
                    mem_stall = 1'b1;
                end else begin
                    req       = 1'b1;
                    mem_stall = 1'b1;
                    cnt_d     = '0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                req   = 1'b1;
                cnt_d = cnt_q + CntW'(1);
                if (dm.dm_ack) begin
                    load_instr = 1'b1;
                    gap_d      = 1'b1;
                    cnt_d      = '0;
                    state_d    = StIdle;
                end else if (timeout_hit) begin
                    req     = 1'b0;
                    mem_err = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign dm.dm_req   = req;
    assign dm.dm_we    = req & is_store;
    assign dm.dm_addr  = {2'b00, maluout[31:2]};
    assign dm.dm_wdata = mdata_b;

    // MEM/WB next state: the instruction on pass-through or ack, a cleared bubble otherwise.
    always_comb begin
        wwreg_d   = 1'b0;
        wm2reg_d  = 1'b0;
        wmo_d     = '0;
        walu_d    = '0;
        wrn_d     = '0;
        wb_type_d = '0;
        wb_num_d  = '0;
        if (load_instr) begin
            wwreg_d   = mwreg;
            wm2reg_d  = is_load;
            wmo_d     = (state_q == StBusy && is_load) ? dm.dm_rdata : 32'h0;
            walu_d    = maluout;
            wrn_d     = mrdrt;
            wb_type_d = MEM_ins_type;
            wb_num_d  = MEM_ins_number;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gap_q     <= 1'b0;
            wwreg_q   <= 1'b0;
            wm2reg_q  <= 1'b0;
            wmo_q     <= '0;
            walu_q    <= '0;
            wrn_q     <= '0;
            wb_type_q <= '0;
            wb_num_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            wwreg_q   <= wwreg_d;
            wm2reg_q  <= wm2reg_d;
            wmo_q     <= wmo_d;
            walu_q    <= walu_d;
            wrn_q     <= wrn_d;
            wb_type_q <= wb_type_d;
            wb_num_q  <= wb_num_d;
        end
    end

    assign wwreg         = wwreg_q;
    assign wm2reg        = wm2reg_q;
    assign wmo           = wmo_q;
    assign walu          = walu_q;
    assign wrn           = wrn_q;
    assign WB_ins_type   = wb_type_q;
    assign WB_ins_number = wb_num_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a scoreboard of expected MEM/WB entries plus
// per-access checks of stall length, request cycles and error pulses.
module tb_mem_access_stage;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] maluout, mdata_b;
    logic [4:0]  mrdrt;
    logic [3:0]  MEM_ins_type, MEM_ins_number;
    logic        mem_stall, mem_err;
    logic        wwreg, wm2reg;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;
    logic [3:0]  WB_ins_type, WB_ins_number;

    mem_access_stage_if dm_bus ();

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .mwreg          (mwreg),
        .mm2reg         (mm2reg),
        .mwmem          (mwmem),
        .maluout        (maluout),
        .mdata_b        (mdata_b),
        .mrdrt          (mrdrt),
        .MEM_ins_type   (MEM_ins_type),
        .MEM_ins_number (MEM_ins_number),
        .dm             (dm_bus),
        .mem_stall      (mem_stall),
        .mem_err        (mem_err),
        .wwreg          (wwreg),
        .wm2reg         (wm2reg),
        .wmo            (wmo),
        .walu           (walu),
        .wrn            (wrn),
        .WB_ins_type    (WB_ins_type),
        .WB_ins_number  (WB_ins_number)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wwreg;
        logic        wm2reg;
        logic [31:0] wmo;
        logic [31:0] walu;
        logic [4:0]  wrn;
        logic [3:0]  typ;
        logic [3:0]  num;
    } wb_t;

    wb_t exp_q[$];
    wb_t mon_e;
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every tagged MEM/WB entry must match the head of the scoreboard; untagged ones are bubbles.
    always @(negedge clk) begin
        if (!rst && (WB_ins_type != 4'h0 || WB_ins_number != 4'h0)) begin
            if (exp_q.size() == 0) begin
                check_eq("wb_unexpected", {24'h0, WB_ins_type, WB_ins_number}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("wb_wwreg", {31'h0, wwreg}, {31'h0, mon_e.wwreg});
                check_eq("wb_wm2reg", {31'h0, wm2reg}, {31'h0, mon_e.wm2reg});
                check_eq("wb_wmo", wmo, mon_e.wmo);
                check_eq("wb_walu", walu, mon_e.walu);
                check_eq("wb_wrn", {27'h0, wrn}, {27'h0, mon_e.wrn});
                check_eq("wb_tags", {24'h0, WB_ins_type, WB_ins_number},
                         {24'h0, mon_e.typ, mon_e.num});
            end
        end else if (!rst) begin
            check_eq("wb_bubble", {30'h0, wwreg, wm2reg}, 32'h0);
        end
    end

    task automatic clear_inputs();
        mwreg          = 1'b0;
        mm2reg         = 1'b0;
        mwmem          = 1'b0;
        maluout        = '0;
        mdata_b        = '0;
        mrdrt          = '0;
        MEM_ins_type   = '0;
        MEM_ins_number = '0;
        dm_bus.dm_ack  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one instruction and act as the memory. ack_at: ack this many cycles after the
    // first dm_req cycle (0 = never). exp_rs: cycle index at which dm_req should first rise.
    task automatic mem_op(input string nm, input logic wreg, input logic m2reg,
                          input logic wmem, input logic [31:0] alu, input logic [31:0] data,
                          input logic [4:0] rn, input logic [3:0] typ, input logic [3:0] num,
                          input int ack_at, input int exp_rs, input logic [31:0] rdata);
        logic access;
        logic misal;
        int   exp_stall, exp_reqs, exp_errs;
        int   req_start, stalls, reqs, errs, err_c;
        bit   done;
        wb_t  e;

        access = m2reg | wmem;
        misal  = access && (alu[1:0] != 2'b00);
        if (!access) begin
            exp_stall = 0; exp_reqs = 0; exp_errs = 0;
        end else if (misal) begin
            exp_stall = 0; exp_reqs = 0; exp_errs = 1;
        end else if (ack_at > 0) begin
            exp_stall = exp_rs + ack_at; exp_reqs = ack_at + 1; exp_errs = 0;
        end else begin
            // The request cycle in IDLE stalls too, so an abort stalls TIMEOUT cycles in all.
            exp_stall = exp_rs + int'(TIMEOUT); exp_reqs = int'(TIMEOUT); exp_errs = 1;
        end

        if (!access || (!misal && ack_at > 0)) begin
            e.wwreg  = wreg;
            e.wm2reg = m2reg & ~wmem;
            e.wmo    = (m2reg && !wmem) ? rdata : 32'h0;
            e.walu   = alu;
            e.wrn    = rn;
            e.typ    = typ;
            e.num    = num;
            exp_q.push_back(e);
        end

        mwreg = wreg; mm2reg = m2reg; mwmem = wmem; maluout = alu; mdata_b = data;
        mrdrt = rn; MEM_ins_type = typ; MEM_ins_number = num;
        dm_bus.dm_rdata = rdata;

        req_start = -1; stalls = 0; reqs = 0; errs = 0; err_c = -1; done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            dm_bus.dm_ack = (ack_at > 0 && req_start >= 0 && c == req_start + ack_at);
            @(negedge clk);
            if (dm_bus.dm_req) begin
                reqs++;
                if (req_start < 0) begin
                    req_start = c;
                    check_eq({nm, "_addr"}, dm_bus.dm_addr, {2'b00, alu[31:2]});
                    check_eq({nm, "_we"}, {31'h0, dm_bus.dm_we}, {31'h0, wmem});
                    if (wmem) check_eq({nm, "_wdata"}, dm_bus.dm_wdata, data);
                end
            end
            if (mem_err) begin
                errs++;
                err_c = c;
            end
            if (mem_stall) stalls++;
            else done = 1;
            @(posedge clk);
            #1;
        end
        clear_inputs();

        check_eq({nm, "_stall_cycles"}, stalls, exp_stall);
        check_eq({nm, "_req_cycles"}, reqs, exp_reqs);
        check_eq({nm, "_err_pulses"}, errs, exp_errs);
        if (access && !misal) check_eq({nm, "_req_start"}, req_start, exp_rs);
        if (access && !misal && ack_at == 0) check_eq({nm, "_err_cycle"}, err_c,
                                                       exp_rs + int'(TIMEOUT));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        dm_bus.dm_rdata = '0;
        #1 rst = 1'b1;
        #2;
        check_eq("rst_ctrl", {29'h0, dm_bus.dm_req, mem_stall, mem_err}, 32'h0);
        check_eq("rst_wb_flags", {30'h0, wwreg, wm2reg}, 32'h0);
        check_eq("rst_wmo", wmo, 32'h0);
        check_eq("rst_walu", walu, 32'h0);
        check_eq("rst_wrn_tags", {19'h0, wrn, WB_ins_type, WB_ins_number}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        mem_op("alu",  1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 4'h1, 4'h1, 0, 0, 32'h0);
        idle(1);
        mem_op("load", 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd9, 4'h2, 4'h1, 3, 0,
               32'hDEADBEEF);
        idle(1);
        mem_op("store", 1'b0, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 5'd0, 4'h3, 4'h1, 1, 0,
               32'h0);
        idle(1);
        mem_op("misal", 1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd4, 4'h2, 4'h2, 1, 0, 32'h0);
        idle(1);
        mem_op("tmo",  1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd6, 4'h2, 4'h3, 0, 0, 32'h0);

        // Late ack after the abort must be ignored.
        dm_bus.dm_ack = 1'b1;
        dm_bus.dm_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        check_eq("late_ack_tmo", {29'h0, dm_bus.dm_req, mem_stall, mem_err}, 32'h0);
        @(posedge clk);
        #1 dm_bus.dm_ack = 1'b0;
        idle(1);

        // Reset in the second BUSY cycle of a load.
        mwreg = 1'b1; mm2reg = 1'b1; maluout = 32'h200; mrdrt = 5'd7;
        MEM_ins_type = 4'h7; MEM_ins_number = 4'h1;
        @(negedge clk);
        check_eq("rst_load_req", {31'h0, dm_bus.dm_req}, 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        #1;
        check_eq("midrst_ctrl", {29'h0, dm_bus.dm_req, mem_stall, mem_err}, 32'h0);
        check_eq("midrst_wb", {30'h0, wwreg, wm2reg}, 32'h0);
        check_eq("midrst_data", wmo | walu, 32'h0);
        check_eq("midrst_tags", {19'h0, wrn, WB_ins_type, WB_ins_number}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 dm_bus.dm_ack = 1'b1;
        @(negedge clk);
        check_eq("late_ack_rst", {29'h0, dm_bus.dm_req, mem_stall, mem_err}, 32'h0);
        @(posedge clk);
        #1 dm_bus.dm_ack = 1'b0;
        mem_op("post_rst", 1'b1, 1'b1, 1'b0, 32'h204, 32'h0, 5'd10, 4'h2, 4'h4, 2, 0,
               32'h0BADF00D);
        idle(1);

        // Back-to-back loads: the second one sees a one-cycle gap before its request.
        mem_op("b2b0", 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd11, 4'h2, 4'h5, 1, 0,
               32'h11111111);
        mem_op("b2b1", 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd12, 4'h2, 4'h6, 2, 1,
               32'h22222222);
        idle(1);

        // Load and store both set: treated as a store, no memory data written back.
        mem_op("ldst", 1'b1, 1'b1, 1'b1, 32'h10, 32'h55, 5'd8, 4'h4, 4'h1, 1, 0,
               32'h99999999);
        idle(3);

        check_eq("sb_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
